// File: rtl/reg_write_demux16_pkg.sv
// Shared constants for the register-bank write path.
package reg_write_demux16_pkg;

  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned REG_COUNT  = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_CNT_W  = 8;

  // Decoded write enable when no write is in flight.
  localparam logic [REG_COUNT-1:0] WEN_IDLE = '0;

endpackage

// File: rtl/reg_write_demux16_if.sv
// Write-request and bank-status bundle for reg_write_demux16.
// master: drives I_WE/I_WADDR/I_WDATA, observes the O_* status.
// slave : the write demux itself.
interface reg_write_demux16_if
  import reg_write_demux16_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_W,
  parameter int unsigned NUM_REGS   = REG_COUNT,
  parameter int unsigned CNT_WIDTH  = REG_CNT_W
);

  logic                           I_WE;
  logic [REG_ADDR_W-1:0]          I_WADDR;
  logic [DATA_WIDTH-1:0]          I_WDATA;
  logic [NUM_REGS-1:0]            O_WEN;
  logic [NUM_REGS*DATA_WIDTH-1:0] O_REGS;
  logic                           O_PEND_VALID;
  logic [REG_ADDR_W-1:0]          O_PEND_ADDR;
  logic [CNT_WIDTH-1:0]           O_WCOUNT;

  modport master (
    output I_WE, I_WADDR, I_WDATA,
    input  O_WEN, O_REGS, O_PEND_VALID, O_PEND_ADDR, O_WCOUNT
  );

  modport slave (
    input  I_WE, I_WADDR, I_WDATA,
    output O_WEN, O_REGS, O_PEND_VALID, O_PEND_ADDR, O_WCOUNT
  );

endinterface

// File: rtl/reg_write_demux16_decoder4_16.sv
// Combinational 4-to-16 one-hot decoder with enable.
// en       : decode enable; output is all zeros when low
// addr     : index to decode
// onehot_c : one-hot result (combinational)
module decoder4_16
  import reg_write_demux16_pkg::*;
(
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] addr,
  output logic [REG_COUNT-1:0]  onehot_c
);

  always_comb begin
    onehot_c = WEN_IDLE;
    if (en) onehot_c[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_write_demux16.sv
// Two-stage write path for the 16-entry register bank.
// I_CLK, I_NRESET : clock, asynchronous active-low reset
// bus.I_WE/I_WADDR/I_WDATA : write request, sampled every rising edge
// bus.O_WEN        : registered one-hot enable of the captured request
// bus.O_REGS       : flattened bank, register k at [16k+15:16k]
// bus.O_PEND_VALID/O_PEND_ADDR : captured-but-uncommitted write
// bus.O_WCOUNT     : committed-write count, wraps
module reg_write_demux16
  import reg_write_demux16_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_W,
  parameter int unsigned NUM_REGS   = REG_COUNT,
  parameter int unsigned CNT_WIDTH  = REG_CNT_W
)(
  input  logic                   I_CLK,
  input  logic                   I_NRESET,
  reg_write_demux16_if.slave     bus
);

  logic                  s1_valid;
  logic [REG_ADDR_W-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [NUM_REGS-1:0]   wen_q;
  logic [NUM_REGS-1:0]   dec_c;
  logic [CNT_WIDTH-1:0]  wcount_q;
  logic [DATA_WIDTH-1:0] bank [NUM_REGS];

  // Decode the incoming request; registered below so O_WEN lines up with stage 1.
  decoder4_16 u_dec (
    .en       (bus.I_WE),
    .addr     (bus.I_WADDR),
    .onehot_c (dec_c)
  );

  // Stage 1: capture request; idle cycles clear the latches so stale addr never leaks.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      wen_q    <= WEN_IDLE;
    end else begin
      s1_valid <= bus.I_WE;
      s1_addr  <= bus.I_WE ? bus.I_WADDR : '0;
      s1_data  <= bus.I_WE ? bus.I_WDATA : '0;
      wen_q    <= dec_c;
    end
  end

  // Stage 2: commit into the bank and count the write.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      for (int k = 0; k < int'(NUM_REGS); k++) bank[k] <= '0;
      wcount_q <= '0;
    end else if (s1_valid) begin
      bank[s1_addr] <= s1_data;
      wcount_q      <= wcount_q + CNT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign bus.O_REGS[g*DATA_WIDTH +: DATA_WIDTH] = bank[g];
  end

  assign bus.O_WEN        = wen_q;
  assign bus.O_PEND_VALID = s1_valid;
  assign bus.O_PEND_ADDR  = s1_addr;
  assign bus.O_WCOUNT     = wcount_q;

endmodule

// File: tb/tb_reg_write_demux16.sv
module tb_reg_write_demux16;
  import reg_write_demux16_pkg::*;

  logic I_CLK = 1'b0;
  logic I_NRESET;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [255:0] exp_regs;

  reg_write_demux16_if bus ();

  reg_write_demux16 dut (
    .I_CLK    (I_CLK),
    .I_NRESET (I_NRESET),
    .bus      (bus)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] addr, input logic [15:0] data);
    bus.I_WE    = we;
    bus.I_WADDR = addr;
    bus.I_WDATA = data;
  endtask

  task automatic do_reset();
    I_NRESET = 1'b0;
    drive(1'b0, 4'd0, 16'h0);
    tick();
    I_NRESET = 1'b1;
    exp_regs = '0;
  endtask

  initial begin
    I_NRESET = 1'b0;
    drive(1'b0, 4'd0, 16'h0);
    exp_regs = '0;

    // Reset held with activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      drive(1'(i % 2 == 0), 4'($urandom_range(0, 15)), 16'($urandom));
      tick();
      check("rst_regs", bus.O_REGS, 256'h0);
      check("rst_wen", 256'(bus.O_WEN), 256'h0);
      check("rst_pend", 256'(bus.O_PEND_VALID), 256'h0);
      check("rst_wcount", 256'(bus.O_WCOUNT), 256'h0);
    end
    drive(1'b0, 4'd0, 16'h0);
    I_NRESET = 1'b1;

    // Single write.
    drive(1'b1, 4'd5, 16'hBEEF);
    tick();
    check("single_wen", 256'(bus.O_WEN), 256'h0020);
    check("single_pend_valid", 256'(bus.O_PEND_VALID), 256'h1);
    check("single_pend_addr", 256'(bus.O_PEND_ADDR), 256'h5);
    check("single_regs_early", bus.O_REGS, 256'h0);
    drive(1'b0, 4'd0, 16'h0);
    tick();
    exp_regs[95:80] = 16'hBEEF;
    check("single_regs", bus.O_REGS, exp_regs);
    check("single_wcount", 256'(bus.O_WCOUNT), 256'h1);
    check("single_idle_wen", 256'(bus.O_WEN), 256'h0);
    check("single_idle_pend", 256'(bus.O_PEND_VALID), 256'h0);

    // Sweep all addresses back to back.
    do_reset();
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 4'(j), 16'h1000 + 16'(j));
      tick();
      check($sformatf("sweep_wen%0d", j), 256'(bus.O_WEN), 256'(16'h1 << j));
      check($sformatf("sweep_paddr%0d", j), 256'(bus.O_PEND_ADDR), 256'(j));
      exp_regs[16*j +: 16] = 16'h1000 + 16'(j);
    end
    drive(1'b0, 4'd0, 16'h0);
    tick();
    check("sweep_regs", bus.O_REGS, exp_regs);
    check("sweep_wcount", 256'(bus.O_WCOUNT), 256'd16);

    // Same address back to back: in-order commit, last wins.
    drive(1'b1, 4'd3, 16'h1111);
    tick();
    drive(1'b1, 4'd3, 16'h2222);
    tick();
    check("same_first", 256'(bus.O_REGS[63:48]), 256'h1111);
    drive(1'b0, 4'd0, 16'h0);
    tick();
    exp_regs[63:48] = 16'h2222;
    check("same_last", bus.O_REGS, exp_regs);
    check("same_wcount", 256'(bus.O_WCOUNT), 256'd18);

    // Undriven address/data while idle must not disturb state.
    bus.I_WE = 1'b0;
    bus.I_WADDR = 'x;
    bus.I_WDATA = 'x;
    tick();
    tick();
    check("x_regs", bus.O_REGS, exp_regs);
    check("x_wen", 256'(bus.O_WEN), 256'h0);
    check("x_paddr", 256'(bus.O_PEND_ADDR), 256'h0);
    check("x_wcount", 256'(bus.O_WCOUNT), 256'd18);

    // Reset between capture and commit discards the pending write.
    drive(1'b1, 4'd9, 16'hA5A5);
    tick();
    check("mid_pend_before", 256'(bus.O_PEND_VALID), 256'h1);
    drive(1'b0, 4'd0, 16'h0);
    #2;
    I_NRESET = 1'b0;
    #1;
    check("mid_pend_async", 256'(bus.O_PEND_VALID), 256'h0);
    check("mid_regs_async", bus.O_REGS, 256'h0);
    tick();
    I_NRESET = 1'b1;
    tick();
    check("mid_reg9", 256'(bus.O_REGS[159:144]), 256'h0);
    check("mid_wcount", 256'(bus.O_WCOUNT), 256'h0);

    // Counter wrap via 256 writes to register 0.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 4'd0, 16'h0001);
      tick();
    end
    check("wrap_pre", 256'(bus.O_WCOUNT), 256'd255);
    drive(1'b0, 4'd0, 16'h0);
    tick();
    check("wrap_wcount", 256'(bus.O_WCOUNT), 256'd0);
    exp_regs[15:0] = 16'h0001;
    check("wrap_regs", bus.O_REGS, exp_regs);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
